instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Front-end stage that feeds Decode. Generates the fetch PC and drives the synchronous instruction memory.
//  Splits each returned 32-bit word into isBranch/format/opcode/prim/sec and presents them with enable_o.
//  Absorbs back-pressure and branch redirects from the back end, and never drops or duplicates an instruction.
// PARAMETERS
//  ADDR_WIDTH  16  fetch address width, word-addressed
//  RESET_PC    0   first fetch address after reset
// PORTS
//  clock_i              in   1           sole clock, rising edge
//  reset_i              in   1           asynchronous, active-low reset
//  enable_i             in   1           1 = fetching allowed; 0 = no new reads issued
//  stall_i              in   1           Decode cannot accept; hold outputs
//  redirect_i           in   1           branch taken / flush; restart at redirectPC_i
//  redirectPC_i         in   ADDR_WIDTH  new fetch address
//  imemReadEn_o         out  1           read strobe (combinational)
//  imemAddr_o           out  ADDR_WIDTH  read address (combinational, = pc)
//  imemData_i           in   32          read data, valid exactly 1 cycle after imemReadEn_o
//  isBranch_o           out  1           word[31]
//  instructionFormat_o  out  1           word[30]; 1 = reg-imm, 0 = reg-reg
//  opcode_o             out  7           word[29:23]
//  primOperand_o        out  5           word[22:18]
//  secOperand_o         out  16          word[17:2]; word[1:0] reserved, ignored
//  pc_o                 out  ADDR_WIDTH  address of the presented instruction
//  enable_o             out  1           presented instruction is valid
// BEHAVIOUR
//  Reset (async, reset_i=0):
//   - pc=RESET_PC, state=IDLE. All outputs and inflight/hold flags are 0.
//  FSM:
//   - IDLE->RUN when enable_i=1. RUN->IDLE when enable_i=0.
//   - RUN->HOLD when returning data meets stall_i=1. HOLD->RUN when the buffer drains.
//   - Any state->IDLE/RUN (per enable_i) on redirect_i.
//  imemReadEn_o = enable_i & (state==RUN) & ~stall_i & ~holdValid & ~redirect_i.
//   - On each issuing edge: pc<=pc+1 (wraps modulo 2^ADDR_WIDTH), inflight<=1, inflightPC<=pc.
//   - Otherwise inflight<=0.
//  Latency:
//   - Read issued in cycle N, data sampled at the end of N+1, fields and enable_o visible in N+2.
//   - Steady state delivers 1 instr/cycle.
//  Edge priority: redirect_i > stall_i > deliver.
//   redirect_i=1:
//    - pc<=redirectPC_i; inflight and holdValid cleared (returning data discarded); enable_o<=0.
//    - First target read is issued the next cycle.
//   stall_i=1:
//    - All field outputs, pc_o and enable_o hold.
//    - If inflight, the data is captured into a 1-entry hold buffer with its PC, and holdValid<=1.
//   stall_i=0:
//    - If holdValid: present the buffer, holdValid<=0.
//    - Else if inflight: present imemData_i.
//    - Else: enable_o<=0 (fields hold their last value).
//    - inflight and holdValid are never both set at one edge, by construction.
//  Boundaries:
//   - After a buffered stall releases, exactly 1 bubble cycle follows.
//   - enable_i dropping mid-stream still delivers the one in-flight word.
//   - redirect_i together with stall_i: redirect wins; enable_o is 0 the next cycle.
//   - pc wraps from 2^ADDR_WIDTH-1 to 0.
// TESTING
//  1. Reset, enable_i=1, mem[0]=0xC11448D0.
//     -> imemAddr_o 0,1,2...; cycle 2 shows isBranch=1, fmt=1, opcode=2, prim=5, sec=0x1234, pc_o=0, enable_o=1.
//  2. Stream mem[0..7]; stall_i=1 for 3 cycles at instr 3.
//     -> instrs 0..7 each appear once, in order; outputs hold during stall; 1 bubble after release.
//  3. redirect_i=1 to 0x0040 while a read is in flight.
//     -> in-flight word never has enable_o=1; next valid pc_o=0x0040 two cycles after the redirect cycle.
//  4. redirect_i and stall_i together with holdValid=1.
//     -> buffer flushed, enable_o=0, fetch restarts at target.
//  5. ADDR_WIDTH=4, RESET_PC=14.
//     -> addresses 14,15,0,1; pc_o follows the same order.
//  6. reset_i low mid-stream, asynchronously.
//     -> enable_o=0 and imemReadEn_o=0 immediately; the first read after release is at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: drives the synchronous instruction memory and presents decoded fields to Decode.
// Read-to-output latency is 2 cycles; a 1-entry hold buffer absorbs the word returning during a stall.
module instruction_fetch #(
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic                  stall_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirectPC_i,
  output logic                  imemReadEn_o,
  output logic [ADDR_WIDTH-1:0] imemAddr_o,
  input  logic [31:0]           imemData_i,
  output logic                  isBranch_o,
  output logic                  instructionFormat_o,
  output logic [6:0]            opcode_o,
  output logic [4:0]            primOperand_o,
  output logic [15:0]           secOperand_o,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  enable_o
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic [ADDR_WIDTH-1:0] hold_pc;
  logic                  inflight;
  logic                  hold_vld;
  logic [29:0]           hold_word;
  logic [29:0]           out_word;
  logic                  read_en;
  logic                  data_unused;

  // Bits [1:0] of the instruction word are reserved.
  assign data_unused = ^imemData_i[1:0];

  assign read_en      = enable_i & (state == RUN) & ~stall_i & ~hold_vld & ~redirect_i;
  assign imemReadEn_o = read_en;
  assign imemAddr_o   = pc;

  assign {isBranch_o, instructionFormat_o, opcode_o, primOperand_o, secOperand_o} = out_word;

  always_comb begin
    state_nxt = state;
    if (redirect_i) begin
      state_nxt = enable_i ? RUN : IDLE;
    end else begin
      case (state)
        IDLE: if (enable_i) state_nxt = RUN;
        RUN: begin
          if (!enable_i)            state_nxt = IDLE;
          else if (inflight && stall_i) state_nxt = HOLD;
        end
        HOLD: if (hold_vld && !stall_i) state_nxt = enable_i ? RUN : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      hold_vld    <= 1'b0;
      hold_word   <= '0;
      hold_pc     <= '0;
      out_word    <= '0;
      pc_o        <= '0;
      enable_o    <= 1'b0;
    end else if (redirect_i) begin
      // Anything in flight or buffered belongs to the abandoned path.
      pc       <= redirectPC_i;
      inflight <= 1'b0;
      hold_vld <= 1'b0;
      enable_o <= 1'b0;
    end else begin
      if (read_en) begin
        pc          <= pc + 1'b1;
        inflight    <= 1'b1;
        inflight_pc <= pc;
      end else begin
        inflight <= 1'b0;
      end

      if (stall_i) begin
        if (inflight) begin
          hold_word <= imemData_i[31:2];
          hold_pc   <= inflight_pc;
          hold_vld  <= 1'b1;
        end
      end else if (hold_vld) begin
        out_word <= hold_word;
        pc_o     <= hold_pc;
        enable_o <= 1'b1;
        hold_vld <= 1'b0;
      end else if (inflight) begin
        out_word <= imemData_i[31:2];
        pc_o     <= inflight_pc;
        enable_o <= 1'b1;
      end else begin
        enable_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: synchronous memory model, in-order delivery scoreboard and directed boundary steps.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        st = 1'b0;
  logic        rd = 1'b0;
  logic [15:0] tgt = '0;
  logic [31:0] imem_data = '0;
  logic        imem_ren;
  logic [15:0] imem_addr;
  logic        is_branch, fmt, enable_o;
  logic [6:0]  opcode;
  logic [4:0]  prim;
  logic [15:0] sec, pc_o;
  logic [29:0] fields;

  assign fields = {is_branch, fmt, opcode, prim, sec};

  instruction_fetch #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clock_i(clk), .reset_i(rst_n), .enable_i(en), .stall_i(st),
    .redirect_i(rd), .redirectPC_i(tgt),
    .imemReadEn_o(imem_ren), .imemAddr_o(imem_addr), .imemData_i(imem_data),
    .isBranch_o(is_branch), .instructionFormat_o(fmt), .opcode_o(opcode),
    .primOperand_o(prim), .secOperand_o(sec), .pc_o(pc_o), .enable_o(enable_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return ({16'h0, a} * 32'h9E3779B1) ^ 32'hC11448D0;
  endfunction

  // Synchronous memory; unread cycles return garbage so stale data cannot pass.
  always @(posedge clk) imem_data <= imem_ren ? mem_word(imem_addr) : $urandom;

  int          vectors = 0;
  int          miscompares = 0;
  int          delivered = 0;
  logic [15:0] exp_pc = '0;
  logic        hold_chk = 1'b0;
  logic [29:0] prev_fields;
  logic [15:0] prev_pc;
  logic        prev_en;
  logic        last_ren;
  logic [15:0] last_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after a falling edge, score what Decode would accept.
  task automatic cyc(input logic e, input logic s, input logic r, input logic [15:0] t);
    logic [31:0] w;
    if (hold_chk) begin
      chk("hold_pc", pc_o, prev_pc);
      chk("hold_fields", fields, prev_fields);
      chk("hold_en", enable_o, prev_en);
    end
    en = e; st = s; rd = r; tgt = t;
    #1;
    last_ren  = imem_ren;
    last_addr = imem_addr;
    if (enable_o && !s) begin
      w = mem_word(exp_pc);
      chk("deliver_pc", pc_o, exp_pc);
      chk("deliver_word", fields, w[31:2]);
      exp_pc = exp_pc + 16'd1;
      delivered++;
    end
    if (r) exp_pc = t;
    hold_chk    = s && !r;
    prev_pc     = pc_o;
    prev_fields = fields;
    prev_en     = enable_o;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_enable_o", enable_o, 0);
    chk("rst_ren", imem_ren, 0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_pc_o", pc_o, 0);
    chk("rst_fields", fields, 0);
    rst_n = 1'b1;

    // First fetch and field split
    cyc(1, 0, 0, 0); chk("idle_no_read", last_ren, 0);
    cyc(1, 0, 0, 0); chk("first_read", last_ren, 1); chk("first_addr", last_addr, 16'h0000);
    cyc(1, 0, 0, 0); chk("second_addr", last_addr, 16'h0001);
    chk("t1_enable", enable_o, 1);
    chk("t1_isbranch", is_branch, 1);
    chk("t1_fmt", fmt, 1);
    chk("t1_opcode", opcode, 7'd2);
    chk("t1_prim", prim, 5'd5);
    chk("t1_sec", sec, 16'h1234);
    chk("t1_pc", pc_o, 16'h0000);

    // Buffered stall of 3 cycles at instruction 3
    for (int i = 0; i < 20 && !(enable_o && pc_o == 16'd3); i++) cyc(1, 0, 0, 0);
    chk("reach_pc3", {enable_o, pc_o}, {1'b1, 16'd3});
    cyc(1, 1, 0, 0); chk("stall_no_read", last_ren, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    chk("release_buf_en", enable_o, 1); chk("release_buf_pc", pc_o, 16'd4);
    cyc(1, 0, 0, 0);
    chk("bubble", enable_o, 0);
    cyc(1, 0, 0, 0);
    chk("after_bubble_en", enable_o, 1); chk("after_bubble_pc", pc_o, 16'd5);

    // Redirect with a read in flight
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 16'h0040);
    chk("redir_flush1", enable_o, 0);
    cyc(1, 0, 0, 0); chk("redir_read", last_ren, 1); chk("redir_addr", last_addr, 16'h0040);
    chk("redir_flush2", enable_o, 0);
    cyc(1, 0, 0, 0);
    chk("redir_target_en", enable_o, 1); chk("redir_target_pc", pc_o, 16'h0040);

    // Redirect together with stall while the hold buffer is full
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 16'h0080);
    chk("rs_flush1", enable_o, 0);
    cyc(1, 0, 0, 0); chk("rs_addr", last_addr, 16'h0080); chk("rs_read", last_ren, 1);
    chk("rs_flush2", enable_o, 0);
    cyc(1, 0, 0, 0);
    chk("rs_target_pc", {enable_o, pc_o}, {1'b1, 16'h0080});

    // Address wrap
    cyc(1, 0, 1, 16'hFFFE);
    cyc(1, 0, 0, 0); chk("wrap_a0", last_addr, 16'hFFFE);
    cyc(1, 0, 0, 0); chk("wrap_a1", last_addr, 16'hFFFF);
    cyc(1, 0, 0, 0); chk("wrap_a2", last_addr, 16'h0000);
    repeat (4) cyc(1, 0, 0, 0);

    // enable_i drop still delivers the in-flight word
    cyc(0, 0, 0, 0); chk("drop_no_read", last_ren, 0);
    chk("drop_inflight_en", enable_o, 1);
    cyc(0, 0, 0, 0);
    chk("drop_drained", enable_o, 0);
    repeat (5) cyc(1, 0, 0, 0);

    // Asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    chk("arst_enable_o", enable_o, 0);
    chk("arst_ren", imem_ren, 0);
    chk("arst_addr", imem_addr, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1; exp_pc = '0; hold_chk = 1'b0;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0); chk("arst_first_read", {last_ren, last_addr}, {1'b1, 16'h0000});

    // Randomized traffic against the scoreboard
    delivered = 0;
    for (int i = 0; i < 500; i++) begin
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 3,
          $urandom_range(0, 31) == 0, 16'($urandom));
    end
    repeat (6) cyc(1, 0, 0, 0);
    chk("rand_progress", delivered > 100, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
